shell_loader: RTL and testbench

Host-side command shell between the UART transceiver and the Hack system core. It parses a byte protocol from the UART receiver, loads program words into instruction ROM over the ROM write bus, and drives the run/shell mode select. In run mode it forwards CPU-originated bytes to the UART transmitter and watches for a break byte that returns control to the shell.

---
 rtl/shell_pkg.sv | 33 +++
 rtl/shell_tx_arb.sv | 102 ++++++++++
 rtl/shell_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_shell_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shell_pkg.sv
// Shared types and protocol constants for the shell loader.
// SHELL_PEEK_EN adds the peek command states.
package shell_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_CNT_HI,
        S_LD_CNT_LO,
        S_LD_HI,
        S_LD_LO,
`ifdef SHELL_PEEK_EN
        S_PK_ADDR_HI,
        S_PK_ADDR_LO,
        S_PK_READ,
`endif
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        TX_EMPTY,
        TX_READY,
        TX_RISE,
        TX_FALL
    } tx_phase_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_PEEK  = 8'h50;
    localparam logic [7:0] CMD_BREAK = 8'h03;
    localparam logic [7:0] RSP_ACK   = 8'h21;
    localparam logic [7:0] RSP_NAK   = 8'h3F;

endpackage

// File: rtl/shell_tx_arb.sv
// Transmit arbiter: 2-deep response queue, 1-byte CPU buffer,
// response-first selection and busy-paced start pulses.
module shell_tx_arb
    import shell_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] push_count,
    input  logic [7:0] push_first,
    input  logic [7:0] push_second,
    input  logic [7:0] cpu_byte,
    input  logic       cpu_valid,
    input  logic       cpu_enable,
    input  logic       tx_busy,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    output logic       rsp_pending,
    output logic       cpu_drop
);

    tx_phase_t  phase, phase_n;
    logic [7:0] rsp_q [2];
    logic [1:0] rsp_count;
    logic [7:0] cpu_buf;
    logic       cpu_full;
    logic       out_is_rsp;
    logic       take_rsp;
    logic       take_cpu;

    assign cpu_drop    = cpu_valid && (!cpu_enable || cpu_full);
    assign rsp_pending = (rsp_count != 2'd0)
                      || (phase != TX_EMPTY && out_is_rsp);

    // Output phase register.
    always_ff @(posedge clk) begin
        if (reset) phase <= TX_EMPTY;
        else       phase <= phase_n;
    end

    // Select next byte (responses first); start only on idle line,
    // then wait for busy to rise and fall before the next byte.
    always_comb begin
        phase_n  = phase;
        tx_start = 1'b0;
        take_rsp = 1'b0;
        take_cpu = 1'b0;
        case (phase)
            TX_EMPTY: begin
                if (rsp_count != 2'd0) begin
                    take_rsp = 1'b1;
                    phase_n  = TX_READY;
                end else if (cpu_full) begin
                    take_cpu = 1'b1;
                    phase_n  = TX_READY;
                end
            end
            TX_READY: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    phase_n  = TX_RISE;
                end
            end
            TX_RISE: if (tx_busy) phase_n = TX_FALL;
            TX_FALL: if (!tx_busy) phase_n = TX_EMPTY;
            default: phase_n = TX_EMPTY;
        endcase
    end

    // Response queue, CPU buffer and the held output byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q[0]   <= 8'h00;
            rsp_q[1]   <= 8'h00;
            rsp_count  <= 2'd0;
            cpu_buf    <= 8'h00;
            cpu_full   <= 1'b0;
            tx_byte    <= 8'h00;
            out_is_rsp <= 1'b0;
        end else begin
            if (take_rsp) begin
                tx_byte    <= rsp_q[0];
                out_is_rsp <= 1'b1;
                rsp_q[0]   <= rsp_q[1];
                rsp_count  <= rsp_count - 2'd1;
            end else if (take_cpu) begin
                tx_byte    <= cpu_buf;
                out_is_rsp <= 1'b0;
                cpu_full   <= 1'b0;
            end
            if (push_count != 2'd0) begin
                rsp_q[0]  <= push_first;
                rsp_q[1]  <= push_second;
                rsp_count <= push_count;
            end
            if (cpu_valid && !cpu_drop) begin
                cpu_buf  <= cpu_byte;
                cpu_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/shell_loader.sv
// Host command shell: ROM loader, run/break control, CPU tx path.
// Define SHELL_PEEK_EN to build the 'P' peek command.
module shell_loader
    import shell_pkg::*;
#(
    parameter int ROM_DEPTH      = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_ready,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_start,
    input  logic        i_tx_busy,
    output logic [15:0] o_rom_addr,
    output logic [15:0] o_rom_wdata,
    output logic        o_rom_write,
    input  logic [15:0] i_rom_rdata,
    output logic        o_mode,
    input  logic [7:0]  i_cpu_byte,
    input  logic        i_cpu_byte_ready,
    output logic        o_overrun
);

    state_t      state, state_n;
    logic [7:0]  hi_q;
    logic [15:0] cnt_q, idx_q, word;
    logic [15:0] rom_addr_q, wdata_q;
    logic [31:0] tmo_q;
    logic        wr_q, mode_q, ovr_q;
    logic        mode_set, mode_clr;
    logic        rx_ok, counting, tmo;
    logic        rsp_pending, cpu_drop;
    logic [1:0]  push_count;
    logic [7:0]  push_first, push_second;

`ifdef SHELL_PEEK_EN
    logic pk_wait_q;
    assign counting = state inside {S_LD_CNT_HI, S_LD_CNT_LO,
                                    S_LD_HI, S_LD_LO,
                                    S_PK_ADDR_HI, S_PK_ADDR_LO};
    assign rx_ok = i_rx_ready && !rsp_pending
                && (state != S_PK_READ);
`else
    logic unused_rdata;
    assign unused_rdata = ^i_rom_rdata;
    assign counting = state inside {S_LD_CNT_HI, S_LD_CNT_LO,
                                    S_LD_HI, S_LD_LO};
    assign rx_ok = i_rx_ready && !rsp_pending;
`endif

    assign tmo = counting && !i_rx_ready
              && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    assign o_rom_write = wr_q && !i_reset;
    assign o_rom_addr  = rom_addr_q;
    assign o_rom_wdata = wdata_q;
    assign o_mode      = mode_q;
    assign o_overrun   = ovr_q;

    // Command state register.
    always_ff @(posedge CLK) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_n;
    end

    // Protocol decode: next state, responses, mode changes.
    always_comb begin
        state_n     = state;
        push_count  = 2'd0;
        push_first  = RSP_ACK;
        push_second = RSP_ACK;
        mode_set    = 1'b0;
        mode_clr    = 1'b0;
        word        = {hi_q, i_rx_byte};
        if (tmo) begin
            state_n    = S_IDLE;
            push_count = 2'd1;
            push_first = RSP_NAK;
        end else if (rx_ok) begin
            case (state)
                S_IDLE: begin
                    if (i_rx_byte == CMD_LOAD) begin
                        state_n = S_LD_CNT_HI;
                    end else if (i_rx_byte == CMD_RUN) begin
                        state_n    = S_RUN;
                        mode_set   = 1'b1;
                        push_count = 2'd1;
`ifdef SHELL_PEEK_EN
                    end else if (i_rx_byte == CMD_PEEK) begin
                        state_n = S_PK_ADDR_HI;
`endif
                    end else begin
                        push_count = 2'd1;
                        push_first = RSP_NAK;
                    end
                end
                S_LD_CNT_HI: state_n = S_LD_CNT_LO;
                S_LD_CNT_LO: begin
                    if (word == 16'd0) begin
                        state_n    = S_IDLE;
                        push_count = 2'd1;
                    end else if ({1'b0, word} > 17'(ROM_DEPTH)) begin
                        state_n    = S_IDLE;
                        push_count = 2'd1;
                        push_first = RSP_NAK;
                    end else begin
                        state_n = S_LD_HI;
                    end
                end
                S_LD_HI: state_n = S_LD_LO;
                S_LD_LO: begin
                    if (idx_q + 16'd1 == cnt_q) begin
                        state_n    = S_IDLE;
                        push_count = 2'd1;
                    end else begin
                        state_n = S_LD_HI;
                    end
                end
`ifdef SHELL_PEEK_EN
                S_PK_ADDR_HI: state_n = S_PK_ADDR_LO;
                S_PK_ADDR_LO: begin
                    if ({1'b0, word} >= 17'(ROM_DEPTH)) begin
                        state_n    = S_IDLE;
                        push_count = 2'd1;
                        push_first = RSP_NAK;
                    end else begin
                        state_n = S_PK_READ;
                    end
                end
`endif
                S_RUN: begin
                    if (i_rx_byte == CMD_BREAK) begin
                        state_n    = S_IDLE;
                        mode_clr   = 1'b1;
                        push_count = 2'd1;
                    end
                end
                default: ;
            endcase
        end
`ifdef SHELL_PEEK_EN
        if (state == S_PK_READ && pk_wait_q) begin
            state_n     = S_IDLE;
            push_count  = 2'd2;
            push_first  = i_rom_rdata[15:8];
            push_second = i_rom_rdata[7:0];
        end
`endif
    end

    // Captured bytes, ROM bus registers, timeout and sticky flags.
    always_ff @(posedge CLK) begin
        if (i_reset) begin
            mode_q     <= 1'b0;
            ovr_q      <= 1'b0;
            wr_q       <= 1'b0;
            rom_addr_q <= 16'h0000;
            wdata_q    <= 16'h0000;
            hi_q       <= 8'h00;
            cnt_q      <= 16'h0000;
            idx_q      <= 16'h0000;
            tmo_q      <= 32'd0;
`ifdef SHELL_PEEK_EN
            pk_wait_q  <= 1'b0;
`endif
        end else begin
            wr_q <= 1'b0;
            if (mode_set)      mode_q <= 1'b1;
            else if (mode_clr) mode_q <= 1'b0;
            if ((i_rx_ready && !rx_ok) || cpu_drop) ovr_q <= 1'b1;
            if (counting && !i_rx_ready && !tmo) tmo_q <= tmo_q + 32'd1;
            else                                 tmo_q <= 32'd0;
            if (rx_ok) begin
                case (state)
                    S_LD_CNT_HI, S_LD_HI: hi_q <= i_rx_byte;
                    S_LD_CNT_LO: begin
                        cnt_q <= word;
                        idx_q <= 16'h0000;
                    end
                    S_LD_LO: begin
                        wr_q       <= 1'b1;
                        rom_addr_q <= idx_q;
                        wdata_q    <= word;
                        idx_q      <= idx_q + 16'd1;
                    end
`ifdef SHELL_PEEK_EN
                    S_PK_ADDR_HI: hi_q <= i_rx_byte;
                    S_PK_ADDR_LO: begin
                        rom_addr_q <= word;
                        pk_wait_q  <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
`ifdef SHELL_PEEK_EN
            if (state == S_PK_READ) pk_wait_q <= 1'b1;
`endif
        end
    end

    shell_tx_arb u_tx_arb (
        .clk         (CLK),
        .reset       (i_reset),
        .push_count  (push_count),
        .push_first  (push_first),
        .push_second (push_second),
        .cpu_byte    (i_cpu_byte),
        .cpu_valid   (i_cpu_byte_ready),
        .cpu_enable  (mode_q),
        .tx_busy     (i_tx_busy),
        .tx_byte     (o_tx_byte),
        .tx_start    (o_tx_start),
        .rsp_pending (rsp_pending),
        .cpu_drop    (cpu_drop)
    );

endmodule

// File: tb/tb_shell_loader.sv
// Self-checking bench for shell_loader with a UART/ROM model
// and a command-level expectation model.
module tb_shell_loader;

    localparam int TMO   = 300;
    localparam int DEPTH = 256;
    localparam logic [7:0] ACK = 8'h21;
    localparam logic [7:0] NAK = 8'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_ready = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] rom_addr, rom_wdata;
    logic        rom_write;
    logic [15:0] rom_rdata = 16'h0000;
    logic        mode;
    logic [7:0]  cpu_byte = 8'h00;
    logic        cpu_ready = 1'b0;
    logic        overrun;

    int tests = 0;
    int fails = 0;
    int uart_cnt = 0;
    logic force_busy = 1'b0;

    logic [7:0]  got_tx[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] got_wr[$];
    logic [31:0] exp_wr[$];
    logic [15:0] rom    [DEPTH];
    logic [15:0] shadow [DEPTH];

    always #5 clk = ~clk;

    assign tx_busy = force_busy || (uart_cnt != 0);

    shell_loader #(
        .ROM_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK              (clk),
        .i_reset          (rst),
        .i_rx_byte        (rx_byte),
        .i_rx_ready       (rx_ready),
        .o_tx_byte        (tx_byte),
        .o_tx_start       (tx_start),
        .i_tx_busy        (tx_busy),
        .o_rom_addr       (rom_addr),
        .o_rom_wdata      (rom_wdata),
        .o_rom_write      (rom_write),
        .i_rom_rdata      (rom_rdata),
        .o_mode           (mode),
        .i_cpu_byte       (cpu_byte),
        .i_cpu_byte_ready (cpu_ready),
        .o_overrun        (overrun)
    );

    // UART transmitter and ROM models.
    always @(posedge clk) begin
        if (tx_start && !tx_busy) uart_cnt <= $urandom_range(6, 2);
        else if (uart_cnt != 0)   uart_cnt <= uart_cnt - 1;
        if (rom_write) rom[rom_addr[7:0]] <= rom_wdata;
        rom_rdata <= rom[rom_addr[7:0]];
    end

    // Record transmitted bytes and ROM writes mid-cycle.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            got_tx.push_back(tx_byte);
            tests++;
            assert (tx_busy === 1'b0) else begin
                fails++;
                $error("FAIL start_busy: busy %0b required 0", tx_busy);
            end
        end
        if (rom_write === 1'b1) got_wr.push_back({rom_addr, rom_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_cpu(input logic [7:0] b);
        @(posedge clk); #1;
        cpu_byte  = b;
        cpu_ready = 1'b1;
        @(posedge clk); #1;
        cpu_ready = 1'b0;
    endtask

    task automatic wait_quiet(input int n, input int budget);
        int left;
        left = budget;
        while (got_tx.size() < n && left > 0) begin
            @(negedge clk);
            left--;
        end
        repeat (14) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, "_txn"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
            check({tag, "_tx"}, 32'(got_tx[i]), 32'(exp_tx[i]));
        check({tag, "_wrn"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check({tag, "_wr"}, got_wr[i], exp_wr[i]);
        got_tx.delete();
        exp_tx.delete();
        got_wr.delete();
        exp_wr.delete();
    endtask

    // Load of n words: 0 acks, above depth naks, else writes then ack.
    task automatic do_load(input int n);
        logic [15:0] w;
        send_rx(8'h4C);
        send_rx(8'(n >> 8));
        send_rx(8'(n));
        if (n == 0) begin
            exp_tx.push_back(ACK);
        end else if (n > DEPTH) begin
            exp_tx.push_back(NAK);
        end else begin
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                send_rx(w[15:8]);
                send_rx(w[7:0]);
                exp_wr.push_back({16'(i), w});
                shadow[i] = w;
            end
            exp_tx.push_back(ACK);
        end
        wait_quiet(1, 400);
        compare($sformatf("load%0d", n));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] b, b1, b2, b3;
        for (int i = 0; i < DEPTH; i++) begin
            rom[i]    = 16'h0000;
            shadow[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_mode", 32'(mode), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_txbyte", 32'(tx_byte), 32'd0);
        check("rst_write", 32'(rom_write), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);

        send_rx(8'h4C); send_rx(8'h00); send_rx(8'h02);
        send_rx(8'h12); send_rx(8'h34); send_rx(8'hAB);
        send_rx(8'hCD);
        check("ld_wr_strobe", 32'(rom_write), 32'd1);
        check("ld_wr_addr", 32'(rom_addr), 32'd1);
        check("ld_wr_data", 32'(rom_wdata), 32'hABCD);
        exp_wr.push_back({16'd0, 16'h1234});
        exp_wr.push_back({16'd1, 16'hABCD});
        shadow[0] = 16'h1234;
        shadow[1] = 16'hABCD;
        exp_tx.push_back(ACK);
        wait_quiet(1, 200);
        check("ld_mode", 32'(mode), 32'd0);
        compare("load_dir");

        repeat (3) do_load($urandom_range(6, 1));
        do_load(0);
        do_load(257);
        do_load(DEPTH);

        send_rx(8'h52);
        check("run_mode", 32'(mode), 32'd1);
        exp_tx.push_back(ACK);
        wait_quiet(1, 200);
        compare("run");

        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_cpu(b);
            exp_tx.push_back(b);
            wait_quiet(1, 200);
            compare("cpu");
        end

        do b = 8'($urandom); while (b == 8'h03);
        send_rx(b);
        wait_quiet(0, 0);
        check("run_keep", 32'(mode), 32'd1);
        compare("run_disc");

        send_rx(8'h03);
        check("brk_mode", 32'(mode), 32'd0);
        exp_tx.push_back(ACK);
        wait_quiet(1, 200);
        compare("brk");

        for (int k = 0; k < 2; k++) begin
            do b = 8'($urandom);
            while (b == 8'h4C || b == 8'h52 || b == 8'h50);
            send_rx(b);
            exp_tx.push_back(NAK);
            wait_quiet(1, 200);
            compare("unk");
        end

`ifdef SHELL_PEEK_EN
        send_rx(8'h50); send_rx(8'h00); send_rx(8'h00);
        exp_tx.push_back(shadow[0][15:8]);
        exp_tx.push_back(shadow[0][7:0]);
        wait_quiet(2, 200);
        compare("peek0");
        b = 8'($urandom);
        send_rx(8'h50); send_rx(8'h00); send_rx(b);
        exp_tx.push_back(shadow[b][15:8]);
        exp_tx.push_back(shadow[b][7:0]);
        wait_quiet(2, 200);
        compare("peek_rnd");
        send_rx(8'h50); send_rx(8'h01); send_rx(8'h00);
        exp_tx.push_back(NAK);
        wait_quiet(1, 200);
        compare("peek_oor");
`else
        send_rx(8'h50);
        exp_tx.push_back(NAK);
        wait_quiet(1, 200);
        compare("peek_off");
`endif

        send_rx(8'h4C); send_rx(8'h00);
        exp_tx.push_back(NAK);
        wait_quiet(1, TMO + 60);
        compare("tmo");
        do_load(1);

        send_rx(8'h4C); send_rx(8'h00); send_rx(8'h04);
        send_rx(8'h12); send_rx(8'h34);
        check("mid_strobe", 32'(rom_write), 32'd1);
        rst = 1'b1;
        #1 check("mid_drop", 32'(rom_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_quiet(0, 0);
        check("mid_mode", 32'(mode), 32'd0);
        compare("mid_rst");

        send_rx(8'h52);
        check("ovr_run", 32'(mode), 32'd1);
        exp_tx.push_back(ACK);
        wait_quiet(1, 200);
        compare("ovr_ack");
        force_busy = 1'b1;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        b3 = 8'($urandom);
        send_cpu(b1);
        send_cpu(b2);
        send_cpu(b3);
        repeat (5) @(negedge clk);
        check("ovr_set", 32'(overrun), 32'd1);
        compare("ovr_hold");
        force_busy = 1'b0;
        exp_tx.push_back(b1);
        exp_tx.push_back(b2);
        wait_quiet(2, 200);
        compare("ovr_tx");
        check("ovr_sticky", 32'(overrun), 32'd1);
        pulse_reset();
        check("ovr_clr", 32'(overrun), 32'd0);
        check("ovr_mode", 32'(mode), 32'd0);

        send_cpu(8'($urandom));
        wait_quiet(0, 0);
        check("shell_cpu", 32'(overrun), 32'd1);
        compare("shell_cpu");
        pulse_reset();
        check("final_ovr", 32'(overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
